// File: rtl/seq_adder_pkg.sv
// Shared types for the chunked sequential adder.
// FSM state encoding and index-width helper.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry slice.
// Also exposes the carry into the top bit for overflow detection.
module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i])
             | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: one CHUNK-bit slice per clock,
// carry held in a register between slices.
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_w(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic             co;
  logic             cm;

  // Single slice adder; the operand slice is selected by idx.
  assign ca = op_a[idx*CHUNK +: CHUNK];
  assign cb = op_b[idx*CHUNK +: CHUNK];

  rca_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a    (ca),
    .b    (cb),
    .cin  (carry),
    .s    (cs),
    .cout (co),
    .c_msb(cm)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[idx*CHUNK +: CHUNK] <= cs;
          carry <= co;
          if (idx == LAST) begin
            cout  <= co;
            ovf   <= co ^ cm;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
